// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned DEF_PC_W    = 8;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned FETCH_CNT_W = 16;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with wrap-bit pointers and a synchronous flush.
module fetch_fifo import fetch_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        hold_q;
  logic [AW:0]   wptr_q, rptr_q;
  logic [AW-1:0] waddr, raddr;

  assign waddr = wptr_q[AW-1:0];
  assign raddr = rptr_q[AW-1:0];
  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (waddr == raddr);

  // When empty, present the last head seen rather than stale storage.
  assign rdata = empty ? hold_q : mem_q[raddr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= rdata;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + (AW+1)'(1);
        if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[waddr] <= wdata;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: fetch PC, instruction-memory requests, prefetch FIFO and redirect flush.
// Define FETCH_STATS_EN to add the fetch_cnt / flush_cnt statistics outputs.
module pc_fetch_unit import fetch_pkg::*; #(
  parameter int unsigned      PC_W       = DEF_PC_W,
  parameter int unsigned      INSTR_W    = DEF_INSTR_W,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0]  RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [PC_W-1:0]             imem_addr,
  output logic                        imem_req,
  input  logic [INSTR_W-1:0]          imem_rdata,
  input  logic                        branch_taken,
  input  logic [PC_W-1:0]             branch_target,
  output logic                        instr_valid,
  output logic [INSTR_W-1:0]          instr,
  output logic [PC_W-1:0]             instr_pc,
  input  logic                        instr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef FETCH_STATS_EN
  ,
  output logic [FETCH_CNT_W-1:0]      fetch_cnt,
  output logic [FETCH_CNT_W-1:0]      flush_cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] pc_q;
  logic            inflight_q;
  logic            push, pop, fifo_full, fifo_empty;
  entry_t          wdata, rdata;

  // The in-flight slot is reserved up front so a response always has room.
  assign imem_req  = !reset && !branch_taken && !fifo_full &&
                     ((int'(fifo_count) + int'(inflight_q)) < int'(FIFO_DEPTH));
  assign imem_addr = fpc_q;

  assign push        = inflight_q && !branch_taken;
  assign pop         = instr_valid && instr_ready && !branch_taken;
  assign wdata.pc    = pc_q;
  assign wdata.instr = imem_rdata;

  assign instr_valid = !fifo_empty;
  assign instr       = rdata.instr;
  assign instr_pc    = rdata.pc;

  always_comb begin
    fpc_d = fpc_q;
    if (branch_taken) fpc_d = branch_target;
    else if (imem_req) fpc_d = fpc_q + PC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      pc_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= imem_req;
      if (imem_req) pc_q <= fpc_q;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (branch_taken),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)         fetch_cnt <= fetch_cnt + FETCH_CNT_W'(1);
      if (branch_taken) flush_cnt <= flush_cnt + FETCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table from reset plus redirect, wrap and reset sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready = 1'b0;
  logic [2:0]  fifo_count;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt, flush_cnt;
`endif

  int total = 0;
  int bad = 0;

  pc_fetch_unit #(
    .PC_W       (8),
    .INSTR_W    (16),
    .FIFO_DEPTH (4),
    .RESET_PC   (8'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .fifo_count    (fifo_count)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [7:0] a);
    return {~a, a};
  endfunction

  // Synchronous instruction memory: word at address a is instr_of(a).
  always @(posedge clk) imem_rdata <= instr_of(imem_addr);

  typedef struct {
    logic       bt;
    logic [7:0] tgt;
    logic       rdy;
    logic       ereq;
    logic [7:0] eaddr;
    logic       evalid;
    logic [7:0] epc;
    logic [2:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic bt, input logic [7:0] tgt, input logic rdy, input logic ereq,
                     input logic [7:0] eaddr, input logic evalid, input logic [7:0] epc,
                     input logic [2:0] ecnt);
    vec_t v;
    v.bt = bt; v.tgt = tgt; v.rdy = rdy; v.ereq = ereq;
    v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next negedge, drive inputs, let combinational outputs settle.
  task automatic cyc(input logic bt, input logic [7:0] tgt, input logic rdy);
    @(negedge clk);
    branch_taken = bt;
    branch_target = tgt;
    instr_ready = rdy;
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    branch_taken = 1'b0;
    branch_target = '0;
    instr_ready = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_pc", 32'(instr_pc), 0);
`ifdef FETCH_STATS_EN
    chk("rst_fetch_cnt", 32'(fetch_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming from reset, 10-cycle stall to full, drain, then a redirect to 8'h40.
    add(0, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 1, 1, 8'h01, 0, 8'h00, 0);
    add(0, 8'h00, 1, 1, 8'h02, 1, 8'h00, 1);
    add(0, 8'h00, 1, 1, 8'h03, 1, 8'h01, 1);
    add(0, 8'h00, 0, 1, 8'h04, 1, 8'h02, 1);
    add(0, 8'h00, 0, 1, 8'h05, 1, 8'h02, 2);
    add(0, 8'h00, 0, 0, 8'h06, 1, 8'h02, 3);
    for (int i = 0; i < 7; i++) add(0, 8'h00, 0, 0, 8'h06, 1, 8'h02, 4);
    add(0, 8'h00, 1, 0, 8'h06, 1, 8'h02, 4);
    add(0, 8'h00, 1, 1, 8'h06, 1, 8'h03, 3);
    add(0, 8'h00, 1, 1, 8'h07, 1, 8'h04, 2);
    add(0, 8'h00, 1, 1, 8'h08, 1, 8'h05, 2);
    add(0, 8'h00, 1, 1, 8'h09, 1, 8'h06, 2);
    add(1, 8'h40, 1, 0, 8'h0A, 1, 8'h07, 2);
    add(0, 8'h00, 1, 1, 8'h40, 0, 8'h00, 0);
    add(0, 8'h00, 1, 1, 8'h41, 0, 8'h00, 0);
    add(0, 8'h00, 1, 1, 8'h42, 1, 8'h40, 1);
    add(0, 8'h00, 1, 1, 8'h43, 1, 8'h41, 1);

    #2;
    do_reset();
    foreach (vecs[i]) begin
      cyc(vecs[i].bt, vecs[i].tgt, vecs[i].rdy);
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].ereq));
      chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].eaddr));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].evalid));
      chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].ecnt));
      if (vecs[i].evalid) begin
        chk($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(vecs[i].epc));
        chk($sformatf("v%0d_instr", i), 32'(instr), 32'(instr_of(vecs[i].epc)));
      end
    end

    // Redirect with 3 entries held, a handshake and a returning response in the same cycle.
    do_reset();
    repeat (4) cyc(0, 8'h00, 0);
    cyc(1, 8'h40, 1);
    chk("br_req", 32'(imem_req), 0);
    chk("br_count_before", 32'(fifo_count), 3);
    chk("br_head_pc", 32'(instr_pc), 32'h00);
`ifdef FETCH_STATS_EN
    chk("br_fetch_cnt_before", 32'(fetch_cnt), 3);
    chk("br_flush_cnt_before", 32'(flush_cnt), 0);
`endif
    cyc(0, 8'h00, 1);
    chk("br_count_after", 32'(fifo_count), 0);
    chk("br_valid_after", 32'(instr_valid), 0);
    chk("br_addr_target", 32'(imem_addr), 32'h40);
    chk("br_req_target", 32'(imem_req), 1);
`ifdef FETCH_STATS_EN
    chk("br_fetch_cnt_after", 32'(fetch_cnt), 3);
    chk("br_flush_cnt_after", 32'(flush_cnt), 1);
`endif
    cyc(0, 8'h00, 1);
    chk("br_stale_dropped", 32'(instr_valid), 0);
    cyc(0, 8'h00, 1);
    chk("br_tgt_valid", 32'(instr_valid), 1);
    chk("br_tgt_pc", 32'(instr_pc), 32'h40);
    chk("br_tgt_instr", 32'(instr), 32'(instr_of(8'h40)));

    // PC wrap from 8'hFE.
    do_reset();
    cyc(1, 8'hFE, 1);
    repeat (2) cyc(0, 8'h00, 1);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_pc;
      exp_pc = 8'hFE + 8'(k);
      cyc(0, 8'h00, 1);
      chk($sformatf("wrap%0d_valid", k), 32'(instr_valid), 1);
      chk($sformatf("wrap%0d_pc", k), 32'(instr_pc), 32'(exp_pc));
      chk($sformatf("wrap%0d_instr", k), 32'(instr), 32'(instr_of(exp_pc)));
    end

    // Reset mid-operation with a response in flight and two entries held.
    do_reset();
    repeat (4) cyc(0, 8'h00, 0);
    chk("mid_count", 32'(fifo_count), 2);
    chk("mid_req", 32'(imem_req), 1);
    do_reset();
    cyc(0, 8'h00, 1);
    chk("restart_req", 32'(imem_req), 1);
    chk("restart_addr", 32'(imem_addr), 32'h00);
    repeat (2) cyc(0, 8'h00, 1);
    chk("restart_valid", 32'(instr_valid), 1);
    chk("restart_pc", 32'(instr_pc), 32'h00);
    chk("restart_count", 32'(fifo_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised instruction-fetch front end. It replaces the current PC mux, PC register and PC+1 adder with one block. It owns the fetch PC, issues word-addressed reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small prefetch FIFO. It handles branch redirects by flushing, and hands instructions to the control unit and register-file decode through a valid/ready handshake.

## Interface
Parameters:
- PC_W, 8: PC and instruction-memory address width.
- INSTR_W, 16: instruction width.
- FIFO_DEPTH, 4: prefetch entries. Must be a power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_W  instruction-memory read address (the fetch PC).
- imem_req  out  1  read request this cycle.
- imem_rdata  in  INSTR_W  read data; valid the cycle after a request.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  PC_W  redirect address; sampled when branch_taken=1.
- instr_valid  out  1  FIFO head is valid.
- instr  out  INSTR_W  FIFO head instruction.
- instr_pc  out  PC_W  PC of the FIFO head.
- instr_ready  in  1  consumer accepts the head this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Fetch PC register fpc. Each request advances it: fpc <= fpc+1, modulo 2^PC_W (PC_W'hFF+1 = 0).
- imem_req = !branch_taken && (fifo_count + inflight < FIFO_DEPTH). inflight is a 1-bit register = imem_req of the previous cycle.
- Response path: when inflight=1 and no flush, push {pc_q, imem_rdata}. pc_q is the registered address of the request.
- Pop: when instr_valid && instr_ready && !branch_taken.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect, when branch_taken=1:
  - The FIFO is cleared.
  - The response arriving this cycle is discarded.
  - No request is issued this cycle.
  - fpc <= branch_target.
  - A handshake in the same cycle is ignored; the head is discarded, not consumed.
- Branch has priority over push, pop and fetch.
- Full: no request is issued. The inflight reservation guarantees the FIFO never overflows.
- Empty: instr_valid=0. instr and instr_pc then hold the last head value; they carry no meaning.

## Timing
- Reset values: fpc=RESET_PC, imem_addr=RESET_PC, imem_req=0, inflight=0, instr_valid=0, instr=0, instr_pc=0, fifo_count=0.
- Cycle 1 after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- Request to instr_valid latency: 2 cycles. The request is in cycle N, data is captured at the end of N+1, and instr_valid=1 in N+2.
- Steady state with instr_ready held high: one instruction per cycle.
- Redirect in cycle B: imem_req=0 in B. The request at branch_target is in B+1, and the first valid target instruction appears in B+3.
- Reset asserted mid-operation clears all state immediately (asynchronous). In-flight data is lost.

## Configuration
- FETCH_STATS_EN defined: two extra outputs are present.
  - fetch_cnt (16 bits): increments on every push.
  - flush_cnt (16 bits): increments on every redirect cycle.
  - Both are cleared by reset and wrap at 16'hFFFF.
- Undefined: these ports and their counters do not exist. Behaviour is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - PC_W and INSTR_W defaults.
  - typedef struct packed {pc, instr} fetch_entry_t.
  - FETCH_CNT_W=16.
- Sub-module fetch_fifo: a parametrised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count.
  - Circular read/write pointers with an extra wrap bit.

## Test plan
- Reset release, instr_ready=1, memory holds word i at address i → instr_pc = 0, 1, 2, 3… with first instr_valid 2 cycles after the first request, then one per cycle.
- instr_ready=0 for 10 cycles → exactly FIFO_DEPTH entries held, fifo_count=4, imem_req=0. On ready, entries drain in order with no duplicates or drops.
- branch_taken=1 with branch_target=8'h40 while the FIFO holds 3 entries → fifo_count=0 next cycle, the stale response is dropped, and the next valid instr_pc=8'h40, 3 cycles after the redirect.
- Fetch from 8'hFE with no stalls → instr_pc sequence FE, FF, 00, 01.
- branch_taken asserted in the same cycle as a valid handshake and a returning response → no push, head discarded, fifo_count=0. With FETCH_STATS_EN, flush_cnt +1 and fetch_cnt unchanged.
- Assert reset while inflight=1 and count=2 → all outputs return to their reset values immediately. After release, fetch restarts at RESET_PC.
